gf180_ram_arbiter: RTL

- Shares one single-port gf180_ram_512x8_wrapper macro between two requesters (port 0 = CPU side, port 1 = video/DMA side).
- Sits directly in front of the macro and owns all of its control pins.
- After reset it optionally clears the whole array, then serves requests with round-robin arbitration.
- Returns read data one cycle after grant and holds it stable until that port's next read completes.

---
 rtl/gf180_ram_pkg.sv | 15 +
 rtl/gf180_ram_arbiter_rr_arb2.sv | 42 ++++
 rtl/gf180_ram_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/gf180_ram_pkg.sv
// Shared types and constants for the gf180 RAM arbiter slice.
package gf180_ram_pkg;

    localparam int AW_DEF = 9;
    localparam int DW_DEF = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Wide enough for any data width; users slice [DW-1:0].
    localparam logic [63:0] WEN_ALL_OFF = '1;

endpackage

// File: rtl/gf180_ram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the port that did not win last is granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_o[0]) begin
            last_d = 1'b0;
        end else if (gnt_o[1]) begin
            last_d = 1'b1;
        end
    end

    // Reset to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/gf180_ram_arbiter.sv
// Shares one single-port 512x8 macro between two requesters: optional clear pass after
// reset, then round-robin access with 1-cycle read return and per-port held read data.
module gf180_ram_arbiter
    import gf180_ram_pkg::*;
#(
    parameter int            AW             = AW_DEF,
    parameter int            DW             = DW_DEF,
    parameter bit            CLEAR_ON_RESET = 1'b1,
    parameter logic [DW-1:0] CLEAR_VALUE    = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          init_done,
    output logic          ram_cen_n,
    output logic          ram_gwen_n,
    output logic [DW-1:0] ram_wen_n,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    input  logic [DW-1:0] ram_q
);

    localparam state_e        RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;
    localparam logic [AW-1:0] CLR_LAST  = '1;
    localparam logic [DW-1:0] WEN_OFF   = WEN_ALL_OFF[DW-1:0];

    state_e        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          init_done_q, init_done_d;
    logic [1:0]    rd_pend_q, rd_pend_d;
    logic [DW-1:0] hold0_q, hold0_d;
    logic [DW-1:0] hold1_q, hold1_d;
    logic [1:0]    gnt;
    logic          run_en;

    // Gating with rst keeps grants off while reset is asserted.
    assign run_en = (state_q == ST_RUN) && !rst;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en_i  (run_en),
        .req_i ({p1_req, p0_req}),
        .gnt_o (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RST_STATE;
            clr_cnt_q   <= '0;
            init_done_q <= !CLEAR_ON_RESET;
            rd_pend_q   <= 2'b00;
            hold0_q     <= '0;
            hold1_q     <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            rd_pend_q   <= rd_pend_d;
            hold0_q     <= hold0_d;
            hold1_q     <= hold1_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        if (state_q == ST_INIT) begin
            if (clr_cnt_q == CLR_LAST) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end else begin
                clr_cnt_d = clr_cnt_q + 1'b1;
            end
        end
        rd_pend_d = {gnt[1] & ~p1_we, gnt[0] & ~p0_we};
        hold0_d   = rd_pend_q[0] ? ram_q : hold0_q;
        hold1_d   = rd_pend_q[1] ? ram_q : hold1_q;
    end

    always_comb begin
        ram_cen_n  = 1'b1;
        ram_gwen_n = 1'b1;
        ram_wen_n  = WEN_OFF;
        ram_a      = '0;
        ram_d      = '0;
        if (!rst && state_q == ST_INIT) begin
            ram_cen_n  = 1'b0;
            ram_gwen_n = 1'b0;
            ram_wen_n  = '0;
            ram_a      = clr_cnt_q;
            ram_d      = CLEAR_VALUE;
        end else if (gnt[0]) begin
            ram_cen_n  = 1'b0;
            ram_gwen_n = !p0_we;
            ram_wen_n  = p0_we ? '0 : WEN_OFF;
            ram_a      = p0_addr;
            ram_d      = p0_wdata;
        end else if (gnt[1]) begin
            ram_cen_n  = 1'b0;
            ram_gwen_n = !p1_we;
            ram_wen_n  = p1_we ? '0 : WEN_OFF;
            ram_a      = p1_addr;
            ram_d      = p1_wdata;
        end
    end

    // Macro Q is only meaningful in the cycle after a read grant; otherwise serve the hold.
    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign p0_rvalid = rd_pend_q[0];
    assign p1_rvalid = rd_pend_q[1];
    assign p0_rdata  = rd_pend_q[0] ? ram_q : hold0_q;
    assign p1_rdata  = rd_pend_q[1] ? ram_q : hold1_q;
    assign init_done = init_done_q;

endmodule
